fetch_queue_stage: RTL
======================

# fetch_queue_stage

Parametrised fetch stage for the pipelined core: owns the PC, issues in-order requests to a variable-latency instruction memory, and buffers returned words with their next-PC values in a DEPTH-entry prefetch queue. Decode drains the queue through a valid/ready handshake. Redirects flush the queue and squash in-flight responses. A fetched HALT word stops fetching and raises a sticky `halted` once decode accepts it.

## Interface
- `DATA_W`, 16, instruction width
- `ADDR_W`, 16, PC / memory address width
- `DEPTH`, 4, prefetch queue entries; power of two, ≥2; also the cap on outstanding memory requests
- `PC_STEP`, 2, PC increment per instruction
- `RESET_PC`, 0, PC value after reset
- `NOP_WORD`, 16'h0800, value driven on `instr` when no valid instruction is available
- `HALT_WORD`, 16'h0000, encoding that stops fetch

- `clk`  in  1  sole clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `doBranch`  in  1  redirect request from execute; takes priority over all other events
- `branchPc`  in  ADDR_W  redirect target
- `imem_req_valid`  out  1  request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_addr`  out  ADDR_W  request address (current PC)
- `imem_rsp_valid`  in  1  response word valid; responses return in request order
- `imem_rsp_data`  in  DATA_W  response word
- `instr`  out  DATA_W  queue-head instruction, or `NOP_WORD` when `instr_valid`=0
- `nextPc`  out  ADDR_W  queue-head PC+PC_STEP, or 0 when `instr_valid`=0
- `instr_valid`  out  1  queue non-empty
- `instr_ready`  in  1  decode accepts the head this cycle
- `halted`  out  1  sticky: HALT_WORD has been accepted by decode

## Operation
- State:
  - PC register
  - `outst` counter, 0..DEPTH: requests accepted, response not yet received
  - `drop` counter, 0..DEPTH: responses still to be discarded
  - queue of {instr, nextPc} with read/write pointers and count
  - `halt_pend` flag
  - `halted` flag
- Credit rule: `imem_req_valid` = ~doBranch & ~halt_pend & ~halted & (count + outst + drop < DEPTH).
  - Every response has a reserved slot, so responses are never refused and there is no response-side ready.
- On a request handshake: PC ← PC+PC_STEP; `outst` increments.
- On a response with `drop`=0:
  - Write {rsp_data, addr_of_that_request+PC_STEP} at the queue tail; `outst` decrements.
  - The PC for each outstanding request is held in a DEPTH-deep in-order PC shadow.
  - If rsp_data == HALT_WORD, set `halt_pend`.
- On a response with `drop`>0: discard the word; `drop` decrements.
- Pop when `instr_valid` & `instr_ready`. If the popped word is HALT_WORD, set `halted`.
- Redirect (`doBranch`=1):
  - PC ← branchPc.
  - Queue emptied; pointers reset.
  - `halt_pend` cleared.
  - `drop` ← drop + outst − (1 if a response arrives this cycle); `outst` ← 0.
  - Any pop in the same cycle is still honoured for handshake purposes, but the flush wins for queue state.
  - `halted` is not cleared by redirect.
- After `halted`=1: no requests; remaining responses are discarded; `instr_valid` stays 0.
- Arithmetic:
  - PC adds wrap modulo 2^ADDR_W; 16'hFFFE+2 → 16'h0000.
  - Counters are $clog2(DEPTH)+1 bits wide.

## Timing
- Reset (async assert; deassert sync to clk):
  - PC=RESET_PC
  - queue empty, outst=0, drop=0, halt_pend=0, halted=0
  - instr_valid=0, instr=NOP_WORD, nextPc=0
- First `imem_req_valid` is asserted in the first cycle after reset deassertion.
- Response-to-output latency: a response at edge N is visible on `instr`/`instr_valid` after edge N.
- With zero-wait memory (ready=1, response one cycle after request) and decode always ready:
  - one instruction per cycle;
  - first `instr_valid` two cycles after reset release.
- Full condition: count+outst+drop == DEPTH deasserts the request in the same cycle, combinationally.
- Simultaneous push and pop on a full queue is legal; count is unchanged.
- Simultaneous push and pop on an empty queue: the pushed word appears next cycle.
- Reset mid-operation: all state is cleared immediately. Memory responses arriving after reset are the environment's responsibility; the bench holds `imem_rsp_valid`=0 across reset.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → instr=16'h0800, instr_valid=0, nextPc=0, halted=0, imem_addr=0; release → imem_req_valid=1, addr 0.
- Streaming: zero-wait memory returning mem[a]=a+16'h1000, decode always ready → instr sequence 16'h1000,16'h1002,… one per cycle, nextPc = 2,4,6,…
- Backpressure: instr_ready=0 for 10 cycles → exactly DEPTH=4 requests issued, then imem_req_valid=0; release → words delivered in order, no loss or duplication.
- Redirect with 3 requests outstanding (3-cycle memory latency): pulse doBranch, branchPc=16'h0040 → next request addr 16'h0040; 3 stale responses dropped; first instr after redirect is mem[16'h0040], nextPc=16'h0042.
- Halt: mem[6]=16'h0000 → no request beyond the credit window after the HALT response; halted=1 the cycle after decode accepts the HALT word; later responses ignored; instr_valid stays 0.
- Wrap: RESET_PC=16'hFFFC → addresses FFFC, FFFE, 0000; nextPc of the FFFE word = 16'h0000.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Fetch stage: owns the PC, issues in-order requests to a variable-latency
// instruction memory and buffers returned words with their next-PC in a prefetch queue.
module fetch_queue_stage #(
    parameter int                 DATA_W    = 16,
    parameter int                 ADDR_W    = 16,
    parameter int                 DEPTH     = 4,
    parameter int                 PC_STEP   = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [DATA_W-1:0]  NOP_WORD  = DATA_W'(16'h0800),
    parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(16'h0000)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              doBranch,
    input  logic [ADDR_W-1:0] branchPc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] nextPc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              halted
);

    localparam int                PTR_W = $clog2(DEPTH);
    localparam int                CNT_W = $clog2(DEPTH) + 1;
    localparam int                SUM_W = CNT_W + 2;
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
    localparam logic [SUM_W-1:0]  CAP   = SUM_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  outst_q, outst_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W-1:0]  sh_wr_q, sh_wr_d, sh_rd_q, sh_rd_d;
    logic              halt_pend_q, halt_pend_d;
    logic              halted_q, halted_d;

    logic [DATA_W-1:0] q_instr_mem [DEPTH];
    logic [ADDR_W-1:0] q_npc_mem   [DEPTH];
    logic [ADDR_W-1:0] sh_pc_mem   [DEPTH];

    logic [SUM_W-1:0]  credit_sum;
    logic              req_fire, rsp_keep, rsp_drop, push, pop;
    logic [DATA_W-1:0] head_instr;
    logic [ADDR_W-1:0] head_npc, rsp_npc;

    // Every response in flight (kept or to be dropped) holds a reserved queue slot.
    assign credit_sum     = SUM_W'(cnt_q) + SUM_W'(outst_q) + SUM_W'(drop_q);
    assign imem_req_valid = ~doBranch & ~halt_pend_q & ~halted_q & (credit_sum < CAP);
    assign imem_addr      = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_keep = imem_rsp_valid & (drop_q == '0);
    assign rsp_drop = imem_rsp_valid & (drop_q != '0);
    assign push     = rsp_keep & ~halted_q & ~doBranch;
    assign rsp_npc  = sh_pc_mem[sh_rd_q] + STEP;

    assign head_instr  = q_instr_mem[rd_q];
    assign head_npc    = q_npc_mem[rd_q];
    assign instr_valid = (cnt_q != '0) & ~halted_q;
    assign pop         = instr_valid & instr_ready;
    assign instr       = instr_valid ? head_instr : NOP_WORD;
    assign nextPc      = instr_valid ? head_npc : '0;
    assign halted      = halted_q;

    always_comb begin
        pc_d        = pc_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        sh_wr_d     = sh_wr_q;
        sh_rd_d     = sh_rd_q;
        halt_pend_d = halt_pend_q;
        halted_d    = halted_q | (pop & (head_instr == HALT_WORD));

        if (doBranch) begin
            // Everything still in flight becomes stale; a response this cycle is one of them.
            pc_d        = branchPc;
            cnt_d       = '0;
            wr_d        = '0;
            rd_d        = '0;
            sh_wr_d     = '0;
            sh_rd_d     = '0;
            halt_pend_d = 1'b0;
            outst_d     = '0;
            drop_d      = drop_q + outst_q - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + STEP;
            end
            outst_d     = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_keep);
            drop_d      = drop_q - CNT_W'(rsp_drop);
            cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
            wr_d        = wr_q + PTR_W'(push);
            rd_d        = rd_q + PTR_W'(pop);
            sh_wr_d     = sh_wr_q + PTR_W'(req_fire);
            sh_rd_d     = sh_rd_q + PTR_W'(rsp_keep);
            halt_pend_d = halt_pend_q | (rsp_keep & (imem_rsp_data == HALT_WORD));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            outst_q     <= '0;
            drop_q      <= '0;
            cnt_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            sh_wr_q     <= '0;
            sh_rd_q     <= '0;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            sh_wr_q     <= sh_wr_d;
            sh_rd_q     <= sh_rd_d;
            halt_pend_q <= halt_pend_d;
            halted_q    <= halted_d;
        end
    end

    // Storage only: occupancy is tracked by the control registers above.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr_mem[wr_q] <= imem_rsp_data;
            q_npc_mem[wr_q]   <= rsp_npc;
        end
        if (req_fire) begin
            sh_pc_mem[sh_wr_q] <= pc_q;
        end
    end

endmodule
